// File: rtl/seq_alu_pkg.sv
// -----------------------------------------------------------------------------
// seq_alu_pkg
// Shared definitions for the multicycle execute-stage ALU:
//   D_WIDTH      default datapath width
//   alu_op_e     op-code encoding seen on op_code (add..or = 0..7)
//   salu_state_e FSM state encoding (IDLE/MUL/DIV/DONE)
//   signed_ovf   two's-complement overflow test for add/sub, used when the
//                SEQ_ALU_OVF_EN build option is enabled
// -----------------------------------------------------------------------------
package seq_alu_pkg;

    localparam int unsigned D_WIDTH = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_MUL = 3'd2,
        ALU_DIV = 3'd3,
        ALU_SLL = 3'd4,
        ALU_SRL = 3'd5,
        ALU_AND = 3'd6,
        ALU_OR  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        SALU_IDLE = 2'd0,
        SALU_MUL  = 2'd1,
        SALU_DIV  = 2'd2,
        SALU_DONE = 2'd3
    } salu_state_e;

    // Overflow when both effective operands share a sign that the result lacks.
    function automatic logic signed_ovf(input logic is_sub, input logic a_msb,
                                        input logic b_msb, input logic r_msb);
        logic b_eff;
        b_eff = is_sub ? ~b_msb : b_msb;
        return (a_msb == b_eff) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// -----------------------------------------------------------------------------
// seq_alu_iter
// Shared WIDTH-step datapath for unsigned shift-add multiply and unsigned
// restoring divide. A 2*WIDTH accumulator holds {high, low}; one adder is
// reused: it adds the multiplicand in mul mode and subtracts the divisor in
// div mode.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   start_i          load operands and arm the WIDTH-step counter
//   div_mode_i       1 = divide, 0 = multiply (sampled on start_i)
//   a_i, b_i         multiplier/dividend, multiplicand/divisor
//   last_o           the step taken at the coming edge is the final one
//   next_lo_o/hi_o   accumulator value after the current step
//                    (mul: product low/high; div: quotient/remainder)
// -----------------------------------------------------------------------------
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = D_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             div_mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] next_lo_o,
    output logic [WIDTH-1:0] next_hi_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   b_q;
    logic               div_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WIDTH-1:0]   acc_hi_s;
    logic [WIDTH-1:0]   acc_lo_s;
    logic [WIDTH+1:0]   add_a_s;
    logic [WIDTH+1:0]   add_b_s;
    logic [WIDTH+1:0]   sum_s;
    logic               cin_s;
    logic [2*WIDTH-1:0] step_s;

    assign acc_hi_s = acc_q[2*WIDTH-1:WIDTH];
    assign acc_lo_s = acc_q[WIDTH-1:0];

    // Shared adder: mul adds the multiplicand when the multiplier LSB is set,
    // div computes (shifted remainder - divisor) with a sign bit as borrow.
    always_comb begin
        add_a_s = {(WIDTH+2){1'b0}};
        add_b_s = {(WIDTH+2){1'b0}};
        cin_s   = 1'b0;
        if (div_q) begin
            add_a_s = {1'b0, acc_hi_s, acc_lo_s[WIDTH-1]};
            add_b_s = ~{2'b00, b_q};
            cin_s   = 1'b1;
        end else begin
            add_a_s = {2'b00, acc_hi_s};
            add_b_s = acc_lo_s[0] ? {2'b00, b_q} : {(WIDTH+2){1'b0}};
            cin_s   = 1'b0;
        end
        sum_s = add_a_s + add_b_s + {{(WIDTH+1){1'b0}}, cin_s};
    end

    // Next accumulator: div shifts a quotient bit in at the bottom and keeps
    // either the difference or the restored remainder; mul shifts the sum
    // (including its carry) right by one.
    always_comb begin
        step_s = acc_q;
        if (div_q) begin
            if (sum_s[WIDTH+1]) begin
                step_s = {add_a_s[WIDTH-1:0], acc_lo_s[WIDTH-2:0], 1'b0};
            end else begin
                step_s = {sum_s[WIDTH-1:0], acc_lo_s[WIDTH-2:0], 1'b1};
            end
        end else begin
            step_s = {sum_s[WIDTH:0], acc_lo_s[WIDTH-1:1]};
        end
    end

    // Operand, accumulator and step-counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= {(2*WIDTH){1'b0}};
            b_q   <= {WIDTH{1'b0}};
            div_q <= 1'b0;
            cnt_q <= {CNT_W{1'b0}};
        end else if (start_i) begin
            acc_q <= {{WIDTH{1'b0}}, a_i};
            b_q   <= b_i;
            div_q <= div_mode_i;
            cnt_q <= CNT_W'(WIDTH);
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            acc_q <= step_s;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign last_o    = (cnt_q == CNT_W'(1));
    assign next_lo_o = step_s[WIDTH-1:0];
    assign next_hi_o = step_s[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Multicycle execute-stage ALU with valid/ready on both sides.
// Single-cycle ops (add/sub/sll/srl/and/or, div-by-zero) have latency 1;
// mul and div run WIDTH iterations in seq_alu_iter (latency WIDTH+1).
// Build option: define SEQ_ALU_OVF_EN to add the 'overflow' output
// (signed add/sub overflow, or mul product not fitting in WIDTH bits).
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (ready only in IDLE)
//   op_code               0 add,1 sub,2 mul,3 div,4 sll,5 srl,6 and,7 or
//   operand1, operand2    A/dividend/shift source, B/divisor/shift amount
//   out_valid / out_ready result handshake
//   result, result_hi     low/high product, quotient/remainder, or result/0
//   div_by_zero           div with operand2 == 0
//   overflow              (SEQ_ALU_OVF_EN only)
// -----------------------------------------------------------------------------
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = D_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
`ifdef SEQ_ALU_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    salu_state_e      state_q, state_d;
    logic             in_ready_q, out_valid_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             dbz_q, dbz_d;
`ifdef SEQ_ALU_OVF_EN
    logic             ovf_q, ovf_d;
    logic             single_ovf_s;
`endif

    alu_op_e          op_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic             op2_zero_s;
    logic             accept_s;
    logic             iter_start_s;
    logic             iter_last_s;
    logic [WIDTH-1:0] iter_lo_s, iter_hi_s;
    logic [WIDTH-1:0] single_s;

    assign op_s       = alu_op_e'(op_code);
    assign shamt_s    = operand2[SHAMT_W-1:0];
    assign op2_zero_s = (operand2 == {WIDTH{1'b0}});
    assign accept_s   = in_valid && in_ready_q;
    assign iter_start_s = accept_s &&
                          ((op_s == ALU_MUL) || ((op_s == ALU_DIV) && !op2_zero_s));

    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (iter_start_s),
        .div_mode_i (op_s == ALU_DIV),
        .a_i        (operand1),
        .b_i        (operand2),
        .last_o     (iter_last_s),
        .next_lo_o  (iter_lo_s),
        .next_hi_o  (iter_hi_s)
    );

    // Single-cycle results, computed straight from the request operands.
    always_comb begin
        case (op_s)
            ALU_ADD: single_s = operand1 + operand2;
            ALU_SUB: single_s = operand1 - operand2;
            ALU_SLL: single_s = operand1 << shamt_s;
            ALU_SRL: single_s = operand1 >> shamt_s;
            ALU_AND: single_s = operand1 & operand2;
            ALU_OR:  single_s = operand1 | operand2;
            default: single_s = {WIDTH{1'b0}};
        endcase
    end

`ifdef SEQ_ALU_OVF_EN
    assign single_ovf_s = ((op_s == ALU_ADD) || (op_s == ALU_SUB)) &&
                          signed_ovf(op_s == ALU_SUB, operand1[WIDTH-1],
                                     operand2[WIDTH-1], single_s[WIDTH-1]);
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SALU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SALU_IDLE: begin
                if (accept_s) begin
                    if (op_s == ALU_MUL) begin
                        state_d = SALU_MUL;
                    end else if ((op_s == ALU_DIV) && !op2_zero_s) begin
                        state_d = SALU_DIV;
                    end else begin
                        state_d = SALU_DONE;
                    end
                end else begin
                    state_d = SALU_IDLE;
                end
            end
            SALU_MUL, SALU_DIV: begin
                if (iter_last_s) begin
                    state_d = SALU_DONE;
                end else begin
                    state_d = state_q;
                end
            end
            SALU_DONE: begin
                if (out_ready) begin
                    state_d = SALU_IDLE;
                end else begin
                    state_d = SALU_DONE;
                end
            end
            default: state_d = SALU_IDLE;
        endcase
    end

    // FSM output logic: result registers load only when entering DONE.
    always_comb begin
        result_d = result_q;
        hi_d     = hi_q;
        dbz_d    = dbz_q;
`ifdef SEQ_ALU_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            SALU_IDLE: begin
                if (accept_s && (op_s == ALU_DIV) && op2_zero_s) begin
                    result_d = {WIDTH{1'b1}};
                    hi_d     = operand1;
                    dbz_d    = 1'b1;
`ifdef SEQ_ALU_OVF_EN
                    ovf_d    = 1'b0;
`endif
                end else if (accept_s && (op_s != ALU_MUL) && (op_s != ALU_DIV)) begin
                    result_d = single_s;
                    hi_d     = {WIDTH{1'b0}};
                    dbz_d    = 1'b0;
`ifdef SEQ_ALU_OVF_EN
                    ovf_d    = single_ovf_s;
`endif
                end else begin
                    result_d = result_q;
                end
            end
            SALU_MUL, SALU_DIV: begin
                if (iter_last_s) begin
                    result_d = iter_lo_s;
                    hi_d     = iter_hi_s;
                    dbz_d    = 1'b0;
`ifdef SEQ_ALU_OVF_EN
                    ovf_d    = (state_q == SALU_MUL) && (iter_hi_s != {WIDTH{1'b0}});
`endif
                end else begin
                    result_d = result_q;
                end
            end
            default: result_d = result_q;
        endcase
    end

    // Output and handshake registers; ready/valid follow the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            hi_q        <= {WIDTH{1'b0}};
            dbz_q       <= 1'b0;
`ifdef SEQ_ALU_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            in_ready_q  <= (state_d == SALU_IDLE);
            out_valid_q <= (state_d == SALU_DONE);
            result_q    <= result_d;
            hi_q        <= hi_d;
            dbz_q       <= dbz_d;
`ifdef SEQ_ALU_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign result_hi   = hi_q;
    assign div_by_zero = dbz_q;
`ifdef SEQ_ALU_OVF_EN
    assign overflow    = ovf_q;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
// Self-checking bench for seq_alu (WIDTH = 32). Expected values come from a
// behavioural model using 64-bit arithmetic, '/', '%' and signed ranges.
// Define SEQ_ALU_OVF_EN to also check the overflow output.
// -----------------------------------------------------------------------------
module tb_seq_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op_code = 3'd0;
    logic [W-1:0] operand1 = '0;
    logic [W-1:0] operand2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         div_by_zero;
`ifdef SEQ_ALU_OVF_EN
    logic         overflow;
`endif

    int           n_checks = 0;
    int           n_fail = 0;
    logic         chk_en = 1'b0;
    logic [W-1:0] exp_r, exp_hi;
    logic         exp_dz, exp_ov;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_code     (op_code),
        .operand1    (operand1),
        .operand2    (operand2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
`ifdef SEQ_ALU_OVF_EN
        ,
        .overflow    (overflow)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the ALU must return for one request.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [W-1:0] hi,
                                  output logic dz, output logic ov, output int lat);
        longint       sa, sb, s;
        logic [63:0]  p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; hi = '0; dz = 1'b0; ov = 1'b0; lat = 1;
        case (op)
            3'd0: begin r = a + b; s = sa + sb; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'd1: begin r = a - b; s = sa - sb; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'd2: begin
                p = {32'd0, a} * {32'd0, b};
                r = p[31:0]; hi = p[63:32]; ov = (hi != 0); lat = W + 1;
            end
            3'd3: begin
                if (b == 0) begin r = '1; hi = a; dz = 1'b1; end
                else begin r = a / b; hi = a % b; lat = W + 1; end
            end
            3'd4: r = a << b[4:0];
            3'd5: r = a >> b[4:0];
            3'd6: r = a & b;
            default: r = a | b;
        endcase
    endfunction

    // Compare process: whenever a result is presented, it must match the model.
    always @(negedge clk) begin
        if (chk_en && out_valid) begin
            check("result", result, exp_r);
            check("result_hi", result_hi, exp_hi);
            check("div_by_zero", div_by_zero, exp_dz);
            check("in_ready_in_done", in_ready, 0);
`ifdef SEQ_ALU_OVF_EN
            check("overflow", overflow, exp_ov);
`endif
        end
    end

    // Issue one request, measure latency, stall for 'hold' cycles, then release.
    // With stall_next set, a follow-on add 1+1 request is held on in_valid
    // during the stall and must not be taken.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input logic stall_next);
        int           lat, exp_lat, waited;
        logic [W-1:0] r, hi;
        logic         dz, ov;
        model(op, a, b, r, hi, dz, ov, exp_lat);
        exp_r = r; exp_hi = hi; exp_dz = dz; exp_ov = ov;
        op_code = op; operand1 = a; operand2 = b; in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("accept_wait", waited < 50, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        chk_en = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (stall_next) begin
                op_code = 3'd0; operand1 = 32'd1; operand2 = 32'd1; in_valid = 1'b1;
            end
            check("stall_out_valid", out_valid, 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        chk_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r, hi;
        logic         dz, ov;
        int           lat;
        logic [2:0]   rop;
        logic [W-1:0] ra, rb;
        int           sel;

        // Pin the model against hand-computed values.
        model(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, r, hi, dz, ov, lat);
        check("model_mul_lo", r, 32'h00000001);
        check("model_mul_hi", hi, 32'hFFFFFFFE);
        check("model_mul_lat", lat, 33);
        model(3'd3, 32'd100, 32'd7, r, hi, dz, ov, lat);
        check("model_div_q", r, 32'd14);
        check("model_div_r", hi, 32'd2);
        model(3'd4, 32'd1, 32'h23, r, hi, dz, ov, lat);
        check("model_sll", r, 32'h8);
        model(3'd1, 32'h80000000, 32'd1, r, hi, dz, ov, lat);
        check("model_sub_ovf", ov, 1);

        // Reset state.
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_result_hi", result_hi, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Directed cases.
        do_op(3'd0, 32'hFFFFFFFF, 32'd1, 0, 1'b0);
        do_op(3'd4, 32'd1, 32'h23, 0, 1'b0);
        do_op(3'd1, 32'd5, 32'd7, 1, 1'b0);
        do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
        do_op(3'd3, 32'd100, 32'd7, 10, 1'b1);
        do_op(3'd0, 32'd1, 32'd1, 0, 1'b0);
        do_op(3'd3, 32'd5, 32'd0, 2, 1'b0);
        do_op(3'd0, 32'h7FFFFFFF, 32'd1, 0, 1'b0);
        do_op(3'd1, 32'h80000000, 32'd1, 0, 1'b0);
        do_op(3'd5, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
        do_op(3'd6, 32'hF0F0A5A5, 32'h0FF0FFFF, 0, 1'b0);
        do_op(3'd7, 32'hF0F00000, 32'h0000000F, 0, 1'b0);

        // Reset in the middle of a multiply.
        op_code = 3'd2; operand1 = 32'd7; operand2 = 32'd9; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_result_hi", result_hi, 0);
        check("midrst_dbz", div_by_zero, 0);
        check("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_release_in_ready", in_ready, 1);
        check("midrst_release_out_valid", out_valid, 0);
        @(negedge clk);
        do_op(3'd0, 32'd2, 32'd3, 0, 1'b0);

        // Randomised requests.
        for (int n = 0; n < 200; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            sel = $urandom_range(0, 3);
            if (sel == 0)      rb = 32'd0;
            else if (sel == 1) rb = 32'($urandom_range(1, 15));
            else               rb = $urandom;
            do_op(rop, ra, rb, $urandom_range(0, 3), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Multicycle, parametrised successor to the combinational datapath ALU, for the execute stage of the MIPS core.
- Single-cycle ops (add/sub/shift/logic) complete in 1 cycle after accept.
- Multiply is a WIDTH-cycle shift-add iteration. It returns a full 2*WIDTH product on result_hi:result.
- Divide is a WIDTH-cycle unsigned restoring divider. It returns quotient and remainder for any divisor, not just powers of two.
- Valid/ready handshake on both sides, so the pipeline stalls on busy.

Parameters:
WIDTH, `D_WIDTH (32), operand/result width; must be >= 4 and a power of two.
SHAMT_W, $clog2(WIDTH), localparam; shift-amount bits taken from operand2.
CNT_W, $clog2(WIDTH)+1, localparam; iteration counter width.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request (state IDLE)
op_code  in  3  0 add, 1 sub, 2 mul, 3 div, 4 sll, 5 srl, 6 and, 7 or
operand1  in  WIDTH  A / dividend / shift source
operand2  in  WIDTH  B / divisor / shift amount (low SHAMT_W bits)
out_valid  out  1  result registers valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  low product, quotient, or single-cycle result
result_hi  out  WIDTH  high product, remainder, or 0 for single-cycle ops
div_by_zero  out  1  set with the result of a div whose operand2 == 0

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Naming: clk, reset_n.
- Reset (at any time, including mid-operation):
  - State returns to IDLE; any in-flight op is discarded.
  - in_ready=0 while reset_n is low, then 1 in IDLE.
  - out_valid=0, result=0, result_hi=0, div_by_zero=0.
- States: IDLE, MUL, DIV, DONE.
- Accept: in_valid && in_ready in IDLE latches op_code and operands.
- IDLE transitions:
  - op 0,1,4,5,6,7 -> DONE. Result is registered at the accept edge, so out_valid rises the next cycle (latency 1).
  - op 2 -> MUL with counter=WIDTH.
  - op 3, operand2 != 0 -> DIV with counter=WIDTH.
  - op 3, operand2 == 0 -> DONE with result=all-ones, result_hi=operand1, div_by_zero=1 (latency 1).
- MUL: one shift-add step per cycle, unsigned. After WIDTH steps -> DONE. out_valid is asserted WIDTH+1 cycles after accept.
- DIV: one restoring step per cycle, unsigned. After WIDTH steps -> DONE with quotient/remainder. Latency WIDTH+1.
- DONE:
  - out_valid=1; result, result_hi and div_by_zero hold stable until out_valid && out_ready.
  - On that cycle -> IDLE.
  - in_ready=0 in DONE, so no same-cycle re-accept. Throughput is at most 1 op per 2 cycles.
- in_ready=0 in MUL, DIV and DONE. in_valid in those states is ignored; the requester must hold it.
- Arithmetic rules:
  - add/sub: modulo 2^WIDTH, no trap.
  - sll/srl: logical shifts by operand2[SHAMT_W-1:0]; upper operand2 bits are ignored.
  - and/or: bitwise.
- result_hi=0 for all single-cycle ops; div_by_zero=0 for every op except div-by-zero.
- Output registers change only on the transition into DONE or on reset.

Optional Feature:
Macro SEQ_ALU_OVF_EN.
- Defined:
  - Adds output port overflow (1 bit).
  - Set in DONE for add/sub when the signed two's-complement result overflows.
  - Set for mul when result_hi != 0 (unsigned product exceeds WIDTH bits).
  - 0 for all other ops; reset value 0.
- Undefined: no port and no logic; behaviour is otherwise identical.

Decomposition:
- define.h additions:
  - `D_WIDTH (existing).
  - ALU op-code constants: `ALU_ADD..`ALU_OR = 0..7.
  - State encodings: `SALU_IDLE=0, `SALU_MUL=1, `SALU_DIV=2, `SALU_DONE=3.
- One natural sub-module: seq_alu_iter. It holds the shared WIDTH-step datapath: 2*WIDTH accumulator, shifter, add/sub-compare, counter. It runs in mul or div mode, and the top module keeps the FSM and output registers.

Test Plan:
- Reset mid-mul: accept mul 7*9, assert reset_n=0 at cycle 5 -> out_valid=0, result=0, in_ready=1 after release; the next add 2+3 returns 5 after 1 cycle.
- Single-cycle ops:
  - add 0xFFFFFFFF+1 -> result 0, result_hi 0, latency 1.
  - sll 1 by operand2=0x23 -> result 0x8 (only 5 bits used).
  - sub 5-7 -> 0xFFFFFFFE.
- Mul: 0xFFFFFFFF*0xFFFFFFFF -> result_hi 0xFFFFFFFE, result 0x00000001; out_valid exactly 33 cycles after accept; overflow=1 if SEQ_ALU_OVF_EN.
- Div:
  - 100/7 -> result 14, result_hi 2, div_by_zero 0, latency 33.
  - 5/0 -> result 0xFFFFFFFF, result_hi 5, div_by_zero 1, latency 1.
- Backpressure: hold out_ready=0 for 10 cycles after a div completes -> outputs stable, in_ready=0, a new in_valid is not accepted; it is accepted the cycle after out_ready=1.
- Signed overflow with SEQ_ALU_OVF_EN: add 0x7FFFFFFF+1 -> result 0x80000000, overflow 1; sub 0x80000000-1 -> overflow 1; add 1+1 -> overflow 0.
